// File: rtl/result_frame_packer.sv
// Collects WINDOW result samples and streams count/sum/min/max
// as a 6-byte frame over a valid/ready byte interface.
module result_frame_packer #(
    parameter int unsigned WINDOW = 8,
    parameter logic [7:0]  HEADER = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  count;
    logic [15:0] sum;
    logic [7:0]  acc_min;
    logic [7:0]  acc_max;

    logic [7:0]  frm_count;
    logic [15:0] frm_sum;
    logic [7:0]  frm_min;
    logic [7:0]  frm_max;

    logic [2:0]  idx;
    logic [2:0]  idx_next;
    logic [7:0]  byte_next;

    logic        accept;
    logic        close;
    logic        last_byte;
    logic [7:0]  nxt_count;
    logic [15:0] nxt_sum;
    logic [7:0]  nxt_min;
    logic [7:0]  nxt_max;

    assign in_ready = (state == COLLECT);
    assign busy     = (state == EMIT);

    // Statistics as they stand after this cycle's sample, if any
    always_comb begin
        accept    = in_valid && (state == COLLECT);
        nxt_count = count;
        nxt_sum   = sum;
        nxt_min   = acc_min;
        nxt_max   = acc_max;
        if (accept) begin
            nxt_count = count + 8'd1;
            nxt_sum   = sum + {8'd0, in_data};
            nxt_min   = (in_data < acc_min) ? in_data : acc_min;
            nxt_max   = (in_data > acc_max) ? in_data : acc_max;
        end
        close = (state == COLLECT) &&
                ((accept && (nxt_count == 8'(WINDOW))) ||
                 (flush && ((count != 8'd0) || accept)));
        last_byte = (state == EMIT) && out_valid && out_ready &&
                    (idx == 3'd5);
    end

    always_comb begin
        idx_next = idx + 3'd1;
        unique case (idx_next)
            3'd1:    byte_next = frm_count;
            3'd2:    byte_next = frm_sum[7:0];
            3'd3:    byte_next = frm_sum[15:8];
            3'd4:    byte_next = frm_min;
            3'd5:    byte_next = frm_max;
            default: byte_next = HEADER;
        endcase
    end

    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: if (close) state_next = EMIT;
            EMIT:    if (last_byte) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 8'd0;
            sum       <= 16'd0;
            acc_min   <= 8'hFF;
            acc_max   <= 8'h00;
            frm_count <= 8'd0;
            frm_sum   <= 16'd0;
            frm_min   <= 8'd0;
            frm_max   <= 8'd0;
            idx       <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            if (close) begin
                frm_count <= nxt_count;
                frm_sum   <= nxt_sum;
                frm_min   <= nxt_min;
                frm_max   <= nxt_max;
                count     <= 8'd0;
                sum       <= 16'd0;
                acc_min   <= 8'hFF;
                acc_max   <= 8'h00;
            end else if (accept) begin
                count   <= nxt_count;
                sum     <= nxt_sum;
                acc_min <= nxt_min;
                acc_max <= nxt_max;
            end
            // First EMIT cycle loads the header; later bytes advance on handshake
            if (state == EMIT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= HEADER;
                    idx       <= 3'd0;
                end else if (out_ready) begin
                    if (idx == 3'd5) begin
                        out_valid <= 1'b0;
                        out_data  <= 8'd0;
                        idx       <= 3'd0;
                    end else begin
                        out_data <= byte_next;
                        idx      <= idx_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_result_frame_packer.sv
// Scoreboard bench for result_frame_packer with WINDOW=4.
module tb_result_frame_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    result_frame_packer #(.WINDOW(4), .HEADER(8'hA5)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [15:0] s,
                              input logic [7:0] mn, input logic [7:0] mx);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        exp_q.push_back(s[7:0]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(mn);
        exp_q.push_back(mx);
    endtask

    // Monitor: a byte transfers at the next rising edge when both are high
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_byte: got %h expected none", out_data);
            end else begin
                check("frame_byte", {8'd0, out_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            cyc();
            n++;
        end
        if (!in_ready) check("send_timeout", 16'd0, 16'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || out_valid) && n < 200) begin
            cyc();
            n++;
        end
        if (busy || out_valid) check("idle_timeout", 16'd0, 16'd1);
        cyc();
    endtask

    initial begin
        int n;
        int hi;
        reset     = 1'b1;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", {8'd0, out_data}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_busy", {15'd0, busy}, 16'd0);

        // Basic window, then count the cycles in_ready stays low
        push_frame(8'd4, 16'd100, 8'd10, 8'd40);
        send(8'd10);
        send(8'd20);
        send(8'd30);
        send(8'd40);
        n = 0;
        while (!in_ready && n < 50) begin
            n++;
            cyc();
        end
        check("in_ready_low_cycles", 16'(n), 16'd7);
        wait_idle();

        // Carry into sum high byte
        push_frame(8'd4, 16'h03FC, 8'hFF, 8'hFF);
        repeat (4) send(8'hFF);
        wait_idle();

        // Early close by flush
        push_frame(8'd2, 16'h0100, 8'h01, 8'hFF);
        send(8'hFF);
        send(8'h01);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_idle();

        // Flush on an empty window must not produce a frame
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid || busy) hi++;
            cyc();
        end
        check("empty_flush_valid", 16'(hi), 16'd0);

        // Backpressure on byte 2, with upstream holding a sample
        push_frame(8'd4, 16'd26, 8'd5, 8'd8);
        send(8'd5);
        send(8'd6);
        send(8'd7);
        send(8'd8);
        in_data  = 8'd99;
        in_valid = 1'b1;
        cyc();
        check("bp_byte0_valid", {15'd0, out_valid}, 16'd1);
        cyc();
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_data", {8'd0, out_data}, 16'h001A);
            check("bp_hold_valid", {15'd0, out_valid}, 16'd1);
            check("bp_in_ready", {15'd0, in_ready}, 16'd0);
            cyc();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_idle();
        push_frame(8'd4, 16'd4, 8'd1, 8'd1);
        repeat (4) send(8'd1);
        wait_idle();

        // Reset after byte 1 has transferred
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h04);
        repeat (4) send(8'd9);
        cyc();
        cyc();
        cyc();
        reset     = 1'b1;
        out_ready = 1'b0;
        cyc();
        reset     = 1'b0;
        out_ready = 1'b1;
        check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        push_frame(8'd4, 16'd10, 8'd1, 8'd4);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        send(8'd4);
        wait_idle();

        // Sample and flush together, count==1 beforehand
        push_frame(8'd2, 16'd10, 8'd3, 8'd7);
        send(8'd7);
        in_data  = 8'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_idle();

        // Flush coinciding with the window-filling sample closes once
        push_frame(8'd4, 16'd10, 8'd1, 8'd4);
        send(8'd1);
        send(8'd2);
        send(8'd3);
        in_data  = 8'd4;
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        wait_idle();
        repeat (20) cyc();

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/result_frame_packer.md
Name: result_frame_packer

Overview:
- Downstream consumer of the 8-bit combined result bus produced by the operand stage (the Y output driving uo_out).
- Collects a window of result samples and computes count, 16-bit sum, min and max.
- Emits the statistics as a 6-byte frame over an 8-bit valid/ready byte stream, for pin-limited readout on the bidirectional IO bank.

Parameters:
- WINDOW, 8, number of samples per frame; legal range 1..255.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  result sample from upstream stage.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- flush  input  1  one-cycle pulse; close the current window early.
- out_data  output  8  frame byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- busy  output  1  high while a frame is being emitted.

Behaviour:
- Reset (synchronous, active-high, highest priority) takes effect at the next rising edge:
  - state=COLLECT, count=0, sum=0, min=8'hFF, max=8'h00.
  - out_valid=0, out_data=0, busy=0, in_ready=1.
  - Any partial window or partially emitted frame is discarded; no frame resumes after reset.
- States:
  - COLLECT: in_ready=1, out_valid=0, busy=0.
  - EMIT: in_ready=0, busy=1.
- Accept rule: a sample is accepted when in_valid && in_ready at a rising edge. On accept:
  - count+=1.
  - sum+=in_data (16-bit, zero-extended; cannot overflow since 255*255 < 65536).
  - min=min(min,in_data); max=max(max,in_data).
- COLLECT->EMIT occurs when either condition holds:
  - the accepted sample makes count==WINDOW; or
  - flush=1 and (count>0 or a sample is accepted in the same cycle).
  - The statistics including that sample are snapshotted into the frame registers.
- Flush with count==0 and no sample accepted in that cycle is ignored. No empty frame is ever emitted.
- Flush while in EMIT is ignored; it is not queued.
- Accumulators are reset to their initial values on the same edge as the snapshot, so collection of the next window starts cleanly.
- EMIT frame order, byte index 0..5: HEADER, count, sum[7:0], sum[15:8], min, max.
- out_valid rises the cycle after entry to EMIT (first edge after the snapshot); byte 0 is presented then.
- Output handshake:
  - out_data and out_valid are registered.
  - While out_valid && !out_ready, out_data must stay stable.
  - On out_valid && out_ready, the next byte appears on the following cycle with no bubble.
  - After byte 5 is accepted: out_valid=0 and state=COLLECT on the next edge; in_ready=1 from that cycle.
- Throughput: minimum 7 cycles from the window-closing sample to re-entry to COLLECT when out_ready is held high.
- in_valid during EMIT is backpressured (in_ready=0); upstream must hold the sample.
- count is 8 bits and never wraps, because WINDOW<=255.

Test Plan:
- WINDOW=4, feed 10,20,30,40 back-to-back with out_ready=1 -> frame A5,04,64,00,0A,28; in_ready low for exactly the 6 emit cycles plus the entry cycle.
- WINDOW=4, four samples of 8'hFF -> A5,04,FC,03,FF,FF (carry into sum high byte).
- WINDOW=8, samples 8'hFF,8'h01 then flush pulse -> A5,02,00,01,01,FF; flush with count==0 -> no out_valid for 20 cycles.
- Backpressure: out_ready=0 for 3 cycles while byte 2 is presented -> out_data stays at the sum low byte, out_valid stays 1, no byte skipped or duplicated; in_valid held high during EMIT -> no sample consumed.
- Reset asserted mid-emit after byte 1 -> next cycle out_valid=0, in_ready=1; the next window of 4 samples (1,2,3,4) yields a clean frame A5,04,0A,00,01,04.
- Sample accepted in the same cycle as flush, count==1 before -> frame count=02 includes that sample.
